// File: rtl/imem_resp_if.sv
// Fetch-request, program-load and response bundle between the PC/decode side and imem_resp.
interface imem_resp_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_ready;
  logic                  flush;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  resp_valid;
  logic [ADDR_WIDTH-1:0] resp_addr;
  logic [DATA_WIDTH-1:0] resp_instr;
  logic                  resp_ready;

  modport master (
    output req_valid, req_addr, flush, wr_en, wr_addr, wr_data, resp_ready,
    input  req_ready, resp_valid, resp_addr, resp_instr
  );

  modport slave (
    input  req_valid, req_addr, flush, wr_en, wr_addr, wr_data, resp_ready,
    output req_ready, resp_valid, resp_addr, resp_instr
  );
endinterface

// File: rtl/imem_resp.sv
// Instruction-memory responder: fixed-latency array read feeding an in-order response FIFO,
// with credit-based request acceptance, branch flush and a program-load write port.
module imem_resp #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2,
  parameter int DEPTH      = 4
) (
  input logic        clk,
  input logic        rst,
  imem_resp_if.slave bus
);
  localparam int WORDS = 2 ** ADDR_WIDTH;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int OW    = CW + 3;

  logic [DATA_WIDTH-1:0] mem_r       [WORDS];
  logic [LATENCY-1:0]    stg_valid_r;
  logic [ADDR_WIDTH-1:0] stg_addr_r  [LATENCY];
  logic [DATA_WIDTH-1:0] stg_data_r  [LATENCY];
  logic [ADDR_WIDTH-1:0] fifo_addr_r [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_r [DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;

  logic [OW-1:0]         occ_s;
  logic                  clear_s;
  logic                  empty_s;
  logic                  req_ready_s;
  logic                  accept_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  resp_valid_s;
  logic [ADDR_WIDTH-1:0] resp_addr_s;
  logic [DATA_WIDTH-1:0] resp_instr_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  assign clear_s  = !rst || bus.flush;
  assign empty_s  = (count_r == '0);
  assign accept_s = bus.req_valid && req_ready_s;
  assign push_s   = stg_valid_r[LATENCY-1];
  assign pop_s    = bus.resp_ready && !empty_s;

  // Credit: every accepted, unconsumed request (pipe or FIFO) holds one FIFO slot.
  always_comb begin
    occ_s = {3'b000, count_r};
    for (int i = 0; i < LATENCY; i++) begin
      occ_s = occ_s + OW'(stg_valid_r[i]);
    end
    req_ready_s = rst && !bus.flush && (occ_s < OW'(DEPTH));
  end

  // Program-load port; writes land even during reset and flush.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read pipeline: the array is sampled at acceptance (old word on a same-edge write).
  always_ff @(posedge clk) begin
    if (clear_s) begin
      stg_valid_r <= '0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        stg_valid_r[i] <= stg_valid_r[i-1];
      end
      stg_valid_r[0] <= accept_s;
    end
    for (int i = LATENCY - 1; i > 0; i--) begin
      stg_addr_r[i] <= stg_addr_r[i-1];
      stg_data_r[i] <= stg_data_r[i-1];
    end
    stg_addr_r[0] <= bus.req_addr;
    stg_data_r[0] <= mem_r[bus.req_addr];
  end

  // Output FIFO; a flush or reset edge drops the exiting response and any pop.
  always_ff @(posedge clk) begin
    if (clear_s) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        fifo_addr_r[wr_ptr_r] <= stg_addr_r[LATENCY-1];
        fifo_data_r[wr_ptr_r] <= stg_data_r[LATENCY-1];
        wr_ptr_r              <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head presentation, forced to zero while empty or held in reset.
  always_comb begin
    resp_valid_s = 1'b0;
    resp_addr_s  = '0;
    resp_instr_s = '0;
    if (rst && !empty_s) begin
      resp_valid_s = 1'b1;
      resp_addr_s  = fifo_addr_r[rd_ptr_r];
      resp_instr_s = fifo_data_r[rd_ptr_r];
    end else begin
      resp_valid_s = 1'b0;
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.resp_valid = resp_valid_s;
  assign bus.resp_addr  = resp_addr_s;
  assign bus.resp_instr = resp_instr_s;

  imem_resp_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk   (clk),
    .clear (clear_s),
    .push  (push_s),
    .pop   (pop_s),
    .count (count_r)
  );
endmodule

module imem_resp_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          clear,
  input logic          push,
  input logic          pop,
  input logic [CW-1:0] count
);
  fifo_no_overflow: assert property (@(posedge clk) disable iff (clear)
    !(push && !pop && (count == CW'(DEPTH))));
endmodule
